mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: AW, default 16, address width; DW, default 16, data width; TIMEOUT, default 15, max cycles waiting on mem_ready before abort (1..255).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req, cpu_we  input  1 each  CPU access request / write enable (port 0).
REQ-005 cpu_addr  input  AW; cpu_wdata  input  DW.
REQ-006 cpu_gnt, cpu_done, cpu_err  output  1 each  grant pulse / completion pulse / timeout flag.
REQ-007 cpu_rdata  output  DW  read data of last completed CPU read.
REQ-008 dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_err, dma_rdata: same directions, widths and meanings for port 1 (loader/DMA).
REQ-009 mem_en, mem_we  output  1 each; mem_addr  output  AW; mem_wdata  output  DW.
REQ-010 mem_rdata  input  DW; mem_ready  input  1  memory completes access in a cycle where mem_en=1 and mem_ready=1.

Function
REQ-011 FSM states SHALL be IDLE, ACCESS, WAIT, DONE; one access in flight at a time.
REQ-012 IDLE: no req -> stay; any req -> assert winner's gnt combinationally that cycle, latch winner's we/addr/wdata and port id, go ACCESS.
REQ-013 Arbitration SHALL be round-robin on a 1-bit last-winner pointer; single requester always wins; both requesting -> port not equal to last winner wins.
REQ-014 Requesters hold req/we/addr/wdata until gnt; gnt is a one-cycle pulse; req after gnt is ignored until that port's done.
REQ-015 ACCESS and WAIT: mem_en=1, mem_we/addr/wdata driven from latched registers only; mem_ready=1 -> DONE, else go/stay WAIT.
REQ-016 Wait counter SHALL clear on entering ACCESS, increment each ACCESS/WAIT cycle without mem_ready; reaching TIMEOUT -> DONE with abort flag set.
REQ-017 DONE: winner's done pulses one cycle; err = abort flag; last-winner updated; next state IDLE (new grant possible the following cycle).
REQ-018 Read completion: rdata register of winning port loads mem_rdata on mem_ready cycle; write or abort loads 0; rdata holds until that port's next done.
REQ-019 Latency: gnt cycle N, mem_en first in N+1, done earliest N+2 (mem_ready in N+1); done at N+1+k+1 for k wait cycles; abort done at N+TIMEOUT+1.
REQ-020 Outputs of non-winning port SHALL stay 0 (gnt/done/err) throughout an access.
REQ-021 mem_ready outside ACCESS/WAIT SHALL be ignored.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, all gnt/done/err=0, both rdata=0, counter=0, last-winner=DMA (CPU wins first tie).
REQ-023 Reset asserted mid-access SHALL abort without done/err pulse; first access after release behaves as after power-up.

Structure
REQ-024 Shared package SHALL hold state encoding (2-bit IDLE=0, ACCESS=1, WAIT=2, DONE=3) and port ids (PORT_CPU=0, PORT_DMA=1).
REQ-025 One sub-module mem_rr_pick (combinational 2-way round-robin select: reqs, last winner -> winner id, grant vector); counter and FSM stay in top.

Verification
REQ-026 CPU read addr 0x0010, mem_ready on first cycle, mem_rdata 0xBEEF -> cpu_gnt cycle N, mem_en N+1, cpu_done N+2, cpu_rdata=0xBEEF, cpu_err=0.
REQ-027 Both req from reset (CPU read 0x0001, DMA write 0x0002 data 0x1234) -> CPU served first, DMA granted cycle after CPU done, mem_we=1 addr 0x0002 wdata 0x1234.
REQ-028 DMA held requesting continuously with CPU requesting repeatedly -> grants strictly alternate CPU, DMA, CPU, DMA over 8 accesses.
REQ-029 CPU read, mem_ready delayed 3 cycles -> mem_en high 4 cycles with stable addr, cpu_done 5 cycles after gnt.
REQ-030 mem_ready never asserted, TIMEOUT=15 -> cpu_done and cpu_err pulse at gnt+16, cpu_rdata=0, arbiter returns IDLE and next request is served.
REQ-031 rst_n driven low during WAIT -> mem_en=0 immediately (same cycle, asynchronous), no done pulse; after release CPU wins a tie.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and port ids for the memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_rr_pick.sv
// rtl/mem_rr_pick.sv - combinational two-way round-robin pick
module mem_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic [1:0] gnt
);

  always_comb begin
    winner = PORT_CPU;
    if (req == 2'b11)
      winner = ~last;
    else if (req[1])
      winner = PORT_DMA;
    gnt = 2'b00;
    if (req != 2'b00)
      gnt = (winner == PORT_DMA) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (CPU/DMA) single-outstanding memory arbiter
// with round-robin grant and a wait-for-ready timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic          cpu_err,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic          dma_err,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t        state;
  logic          port;
  logic          last;
  logic          abort;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [7:0]    wait_cnt;
  logic          winner;
  logic [1:0]    pick_gnt;
  logic          active;
  logic          granting;
  logic [DW-1:0] fill;

  mem_rr_pick u_pick (
    .req    ({dma_req, cpu_req}),
    .last   (last),
    .winner (winner),
    .gnt    (pick_gnt)
  );

  assign active    = (state == S_ACCESS) || (state == S_WAIT);
  assign mem_en    = active;
  assign mem_we    = active & lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  // Grant is combinational in IDLE; rst_n gating keeps it quiet while reset is held.
  assign granting = rst_n && (state == S_IDLE);
  assign cpu_gnt  = granting & pick_gnt[0];
  assign dma_gnt  = granting & pick_gnt[1];

  assign cpu_done = (state == S_DONE) && (port == PORT_CPU);
  assign dma_done = (state == S_DONE) && (port == PORT_DMA);
  assign cpu_err  = cpu_done & abort;
  assign dma_err  = dma_done & abort;

  // Writes and aborted accesses leave zero in the requester's read register.
  assign fill = (mem_ready && !lat_we) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      port      <= PORT_CPU;
      last      <= PORT_DMA;
      abort     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_gnt != 2'b00) begin
            port     <= winner;
            abort    <= 1'b0;
            wait_cnt <= '0;
            state    <= S_ACCESS;
            if (winner == PORT_DMA) begin
              lat_we    <= dma_we;
              lat_addr  <= dma_addr;
              lat_wdata <= dma_wdata;
            end else begin
              lat_we    <= cpu_we;
              lat_addr  <= cpu_addr;
              lat_wdata <= cpu_wdata;
            end
          end
        end
        S_ACCESS, S_WAIT: begin
          if (mem_ready || (wait_cnt + 8'd1 == TO)) begin
            state <= S_DONE;
            abort <= !mem_ready;
            if (port == PORT_DMA)
              dma_rdata <= fill;
            else
              cpu_rdata <= fill;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            state    <= S_WAIT;
          end
        end
        S_DONE: begin
          last  <= port;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
